// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control front-end for the BCD stopwatch.
//   Debounces the raw start/stop and clear buttons, runs the IDLE/RUN/PAUSE
//   state machine and produces the prescaled count-enable tick plus a
//   registered clear pulse for the digit chain.
// Ports:
//   clk        system clock, single domain
//   reset      synchronous, active-high reset
//   btn_start  raw start/stop button (asynchronous, bouncy)
//   btn_clear  raw clear button (asynchronous, bouncy)
//   tick       1-cycle count enable, every DIV cycles while running
//   clear      1-cycle registered pulse that zeroes the digit chain
//   running    high in RUN
//   paused     high in PAUSE

// stopwatch_debounce: 2-FF synchronizer, hold-time debounce and rising-edge
// press detector for one button.
//   clk, reset  clock and synchronous active-high reset
//   btn         raw asynchronous button input
//   press       high for one cycle after the debounced level rises
module stopwatch_debounce #(
  parameter int unsigned DB_N = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam logic [DB_N-1:0] CNT_LAST = '1;

  logic            sync_a;
  logic            sync_b;
  logic            level;
  logic            level_d;
  logic [DB_N-1:0] cnt;

  // Synchronizer, hold counter and stable level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_a  <= btn;
      sync_b  <= sync_a;
      level_d <= level;
      // Any return to the stable level restarts the hold window.
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_N'(1);
      end
    end
  end

  // Releases produce no event; only the rising debounced level counts.
  assign press = level & ~level_d;

endmodule

module stopwatch_ctrl #(
  parameter int unsigned DIV  = 5000000,
  parameter int unsigned DB_N = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start,
  input  logic btn_clear,
  output logic tick,
  output logic clear,
  output logic running,
  output logic paused
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  logic          start_ev;
  logic          clear_ev;
  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic          clear_nxt;

  // Button front-ends.
  stopwatch_debounce #(.DB_N(DB_N)) u_db_start (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start),
    .press (start_ev)
  );

  stopwatch_debounce #(.DB_N(DB_N)) u_db_clear (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_clear),
    .press (clear_ev)
  );

  // State, prescaler and clear pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      presc <= '0;
      clear <= 1'b0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      clear <= clear_nxt;
    end
  end

  // Next-state logic; clear takes priority over a simultaneous start.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    clear_nxt = 1'b0;
    if (clear_ev) begin
      state_nxt = ST_IDLE;
      presc_nxt = '0;
      clear_nxt = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ev) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          // Pausing freezes the prescaler so a resume continues the period.
          if (start_ev) begin
            state_nxt = ST_PAUSE;
          end else if (presc == P_LAST) begin
            presc_nxt = '0;
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (start_ev) state_nxt = ST_RUN;
        end
        default: begin
          state_nxt = ST_IDLE;
          presc_nxt = '0;
        end
      endcase
    end
  end

  // Output decode.
  assign tick    = (state == ST_RUN) && (presc == P_LAST);
  assign running = (state == ST_RUN);
  assign paused  = (state == ST_PAUSE);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: randomized bench for stopwatch_ctrl with a behavioural
// reference model (button history windows, mode variable, integer prescaler).
module tb_stopwatch_ctrl;

  localparam int unsigned DIV  = 5;
  localparam int unsigned DB_N = 2;
  localparam int HOLD = 1 << DB_N;

  logic clk = 1'b0;
  logic reset;
  logic btn_start;
  logic btn_clear;
  logic tick;
  logic clear;
  logic running;
  logic paused;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DIV(DIV), .DB_N(DB_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .tick      (tick),
    .clear     (clear),
    .running   (running),
    .paused    (paused)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: index 0 = start button, 1 = clear button.
  int m_mode;   // 0 idle, 1 run, 2 pause
  int m_p;
  bit m_clear;
  bit m_raw1 [2];
  bit m_raw2 [2];
  bit m_lvl [2];
  bit m_lvl_d [2];
  bit hist [2][HOLD];
  int hist_n [2];
  bit started = 1'b0;

  task automatic model_step(input bit r, input bit b0, input bit b1);
    bit ev [2];
    bit all_diff;
    if (r) begin
      m_mode = 0; m_p = 0; m_clear = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_raw1[i] = 1'b0; m_raw2[i] = 1'b0; m_lvl[i] = 1'b0; m_lvl_d[i] = 1'b0;
        hist_n[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) ev[i] = m_lvl[i] && !m_lvl_d[i];
      for (int i = 0; i < 2; i++) begin
        // A new level is accepted once the last HOLD synchronized samples all disagree with it.
        for (int j = HOLD - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = m_raw2[i];
        if (hist_n[i] < HOLD) hist_n[i]++;
        m_lvl_d[i] = m_lvl[i];
        all_diff = (hist_n[i] == HOLD);
        for (int j = 0; j < HOLD; j++) if (hist[i][j] == m_lvl[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[i] = m_raw2[i];
          hist_n[i] = 0;
        end
      end
      m_raw2[0] = m_raw1[0]; m_raw1[0] = b0;
      m_raw2[1] = m_raw1[1]; m_raw1[1] = b1;
      m_clear = 1'b0;
      if (ev[1]) begin
        m_mode = 0; m_p = 0; m_clear = 1'b1;
      end else if (ev[0]) begin
        m_mode = (m_mode == 1) ? 2 : 1;
      end else if (m_mode == 1) begin
        m_p = (m_p + 1) % DIV;
      end
    end
  endtask

  // One clock: apply inputs, compare against the model, advance both.
  task automatic drive(input bit r, input bit b0, input bit b1);
    reset = r; btn_start = b0; btn_clear = b1;
    if (started) begin
      check("tick",    32'(tick),    32'(m_mode == 1 && m_p == DIV - 1));
      check("clear",   32'(clear),   32'(m_clear));
      check("running", 32'(running), 32'(m_mode == 1));
      check("paused",  32'(paused),  32'(m_mode == 2));
    end
    model_step(r, b0, b1);
    started = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold(input bit b0, input bit b1, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, b0, b1);
  endtask

  int run_edge;
  int tick_edge;
  int tick_cnt;

  initial begin
    reset = 1'b1; btn_start = 1'b0; btn_clear = 1'b0;
    @(negedge clk);

    // Reset held with buttons toggling.
    for (int i = 0; i < 3; i++) drive(1'b1, i[0], ~i[0]);
    check("idle_after_reset", 32'({running, paused, tick, clear}), 32'd0);

    // Bouncy start: toggles every 2 cycles never register.
    for (int i = 0; i < 20; i++) drive(1'b0, ((i / 2) % 2) == 1, 1'b0);
    check("bounce_no_run", 32'(running), 32'd0);
    hold(1'b0, 1'b0, 8);

    // Clean start held from reset release: measured latency to running and ticks.
    drive(1'b1, 1'b0, 1'b0);
    run_edge = -1; tick_edge = -1; tick_cnt = 0;
    for (int n = 1; n <= 30; n++) begin
      drive(1'b0, 1'b1, 1'b0);
      if (running === 1'b1 && run_edge < 0) run_edge = n;
      if (tick === 1'b1) begin
        if (tick_edge < 0) tick_edge = n;
        tick_cnt++;
      end
    end
    check("run_latency", 32'(run_edge), 32'(HOLD + 3));
    check("first_tick", 32'(tick_edge), 32'(HOLD + 3 + DIV - 1));
    check("tick_count", 32'(tick_cnt), 32'((30 - (HOLD + 3 + DIV - 1)) / DIV + 1));

    // Pause, then resume, then clear while running.
    hold(1'b0, 1'b0, 9);
    hold(1'b1, 1'b0, 9);
    check("paused_state", 32'(paused), 32'd1);
    hold(1'b0, 1'b0, 12);
    hold(1'b1, 1'b0, 9);
    check("resumed_state", 32'(running), 32'd1);
    hold(1'b0, 1'b0, 3);
    hold(1'b0, 1'b1, 9);
    check("cleared_state", 32'({running, paused}), 32'd0);
    hold(1'b0, 1'b0, 9);

    // Start, pause, then start and clear together from PAUSE.
    hold(1'b1, 1'b0, 9);
    hold(1'b0, 1'b0, 9);
    hold(1'b1, 1'b0, 9);
    hold(1'b0, 1'b0, 9);
    check("pause_before_both", 32'(paused), 32'd1);
    hold(1'b1, 1'b1, 12);
    check("both_to_idle", 32'({running, paused}), 32'd0);
    hold(1'b0, 1'b0, 9);

    // Randomized button activity with occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 2)); k++)
          drive(1'b1, 1'($urandom), 1'($urandom));
      end else begin
        hold(1'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(1, 14)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
